regfile_multiport: RTL and testbench
====================================

// Module: regfile_multiport
// PURPOSE
//  Parametrised register file for the multicycle datapath: NR async read ports, one sync write port.
//  Adds optional hardwired-zero register, write-to-read bypass, synchronous reset and a hardware clear
//  sequencer that zeroes the array one entry per cycle. BUSY reports when the clear is running.
//  Sits in the decode/writeback path; the control FSM stalls on BUSY.
// PARAMETERS
//  DW        32  data width in bits
//  AW        5   address width; DEPTH = 2**AW entries
//  NR        2   number of read ports (1..4)
//  ZERO_REG  1   1: entry 0 always reads 0 and writes to it are dropped
//  BYPASS    0   1: a same-cycle write to a read address is forwarded to that read port
// PORTS
//  CLK    in   1       clock, all state updates on rising edge
//  RST_N  in   1       synchronous reset, active low
//  CLR    in   1       request a hardware clear of the whole array (sampled in IDLE only)
//  WE3    in   1       write enable
//  A3     in   AW      write address
//  WD3    in   DW      write data
//  RA     in   NR*AW   packed read addresses; port k = RA[k*AW +: AW]
//  RD     out  NR*DW   packed read data; port k = RD[k*DW +: DW]
//  BUSY   out  1       clear in progress; writes ignored and all RD forced to 0
// BEHAVIOUR
//  - State machine states: IDLE, CLEAR. Clear pointer ptr has AW bits.
//  - Reset: any rising edge with RST_N=0 sets state=CLEAR and ptr=0, so BUSY=1 and every RD=0.
//    Reset asserted during a clear restarts the clear from ptr=0. The array is not reset in one cycle.
//  - CLEAR: each edge writes mem[ptr]=0 and increments ptr. The edge that clears ptr=DEPTH-1 moves to IDLE.
//    After RST_N rises, BUSY drops exactly DEPTH edges later. ptr wrap to 0 is never observed in CLEAR.
//  - IDLE, CLR=1: next state is CLEAR with ptr=0. CLR takes priority: a WE3 on the same edge is dropped.
//  - IDLE, CLR=0, WE3=1: mem[A3]<=WD3 on the edge. If ZERO_REG=1 and A3=0, no write takes place.
//  - CLEAR: WE3 and CLR are ignored. CLR held high does not restart the clear.
//  - Reads are combinational with 0-cycle latency: RD[k] = mem[RA[k]]. The write becomes visible after the edge.
//  - Read-data priority per port k, highest first:
//    1. BUSY gives 0.
//    2. ZERO_REG and RA[k]=0 gives 0.
//    3. BYPASS, WE3, !CLR and A3==RA[k] gives WD3.
//    4. Otherwise mem[RA[k]].
//  - Several ports may read the same address; each port sees an identical value.
//  - BUSY = (state==CLEAR); this is a registered state decode with no combinational path from inputs.
//  - Widths: no arithmetic on data. ptr increments modulo 2**AW. NR*AW and NR*DW are exact.
// STRUCTURE
//  - regfile_pkg:
//    - state typedef rf_state_t {IDLE, CLEAR};
//    - localparam ST_IDLE=1'b0, ST_CLEAR=1'b1.
//  - Sub-module regfile_clear_fsm:
//    - owns state and ptr;
//    - inputs: CLK, RST_N, CLR, DEPTH-1 compare;
//    - outputs: busy, clr_we, clr_addr.
//  - Top level muxes the write port between the FSM (zero data) and WE3/A3/WD3.
//  - Top level also holds the storage array and generates the NR read muxes in a generate loop.
// TESTING
//  1. Reset then clear timing (DW=32, AW=5, NR=2):
//     - RST_N=0 for 2 cycles, then 1 -> BUSY=1 for exactly 32 edges, then 0.
//     - RD0 and RD1 both 0 during the clear and after it.
//  2. Write then read:
//     - WE3=1, A3=7, WD3=0xDEADBEEF -> after the edge, RA0=7 gives RD0=0xDEADBEEF.
//     - With BYPASS=0, RD0 is the old value in the write cycle.
//  3. Zero register:
//     - ZERO_REG=1, write A3=0, WD3=0xFFFFFFFF -> RA0=0 gives RD0=0.
//     - ZERO_REG=0 run of the same stimulus -> RD0=0xFFFFFFFF.
//  4. Bypass:
//     - BYPASS=1, WE3=1, A3=5, WD3=0x1234, RA1=5 -> RD1=0x1234 in the same cycle.
//     - RA0=6 is unaffected.
//  5. Clear and write collisions:
//     - Fill regs 1..31 with nonzero data, pulse CLR=1 with WE3=1, A3=3 -> write is dropped.
//     - BUSY is high for 32 cycles and all registers read 0 afterwards.
//     - WE3 pulses during BUSY have no effect.
//  6. Reset mid-clear:
//     - RST_N=0 at ptr=10 -> BUSY stays 1; after release a further 32 edges are needed before BUSY=0.
//     - NR=3 run: the third port RA2/RD2 matches ports 0 and 1 on identical addresses.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types for the multiport register file: clear-sequencer state encoding.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_t;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_CLEAR = 1'b1;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks a pointer over the whole array writing zeros, then idles.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_last,
    output logic          o_busy,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr
);

    rf_state_t     r_state;
    rf_state_t     w_state_nxt;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] w_ptr_nxt;

    // State and pointer registers; reset restarts the clear from entry 0
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next-state logic; CLR is only honoured from IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (i_clr) begin
                    w_state_nxt = CLEAR;
                    w_ptr_nxt   = '0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CLEAR: begin
                w_ptr_nxt = r_ptr + {{(AW-1){1'b0}}, 1'b1};
                if (i_last) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = CLEAR;
                end
            end
            default: begin
                w_state_nxt = CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign o_busy     = (r_state == CLEAR);
    assign o_clr_we   = (r_state == CLEAR);
    assign o_clr_addr = r_ptr;

endmodule

// File: rtl/regfile_multiport.sv
// Register file with NR combinational read ports, one write port, optional zero
// register and write bypass, and a hardware clear sequencer that reports BUSY.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NR       = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_we3,
    input  logic [AW-1:0]    i_a3,
    input  logic [DW-1:0]    i_wd3,
    input  logic [NR*AW-1:0] i_ra,
    output logic [NR*DW-1:0] o_rd,
    output logic             o_busy
);

    localparam int            DEPTH = 2 ** AW;
    localparam logic [AW-1:0] LAST  = {AW{1'b1}};

    logic [DW-1:0] r_mem [DEPTH];

    logic          w_busy;
    logic          w_clr_we;
    logic [AW-1:0] w_clr_addr;
    logic          w_last;
    logic          w_user_we;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic [DW-1:0] w_wr_data;

    assign w_last = (w_clr_addr == LAST);

    regfile_clear_fsm #(
        .AW (AW)
    ) u_clear_fsm (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (i_clr),
        .i_last     (w_last),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    // User write: dropped during clear, on a CLR request, in reset, or to the zero register
    always_comb begin
        w_user_we = 1'b0;
        if (w_busy || i_clr || !i_rst_n) begin
            w_user_we = 1'b0;
        end else if ((ZERO_REG == 1) && (i_a3 == {AW{1'b0}})) begin
            w_user_we = 1'b0;
        end else begin
            w_user_we = i_we3;
        end
    end

    // Write-port mux: the clear sequencer owns the port while busy
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
        if (w_clr_we) begin
            w_wr_en   = 1'b1;
            w_wr_addr = w_clr_addr;
            w_wr_data = '0;
        end else begin
            w_wr_en   = w_user_we;
            w_wr_addr = i_a3;
            w_wr_data = i_wd3;
        end
    end

    // Storage array write
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic [DW-1:0] w_rd;

        assign w_ra = i_ra[k*AW +: AW];

        // Read mux in priority order: busy, zero register, bypass, array
        always_comb begin
            w_rd = '0;
            if (w_busy) begin
                w_rd = '0;
            end else if ((ZERO_REG == 1) && (w_ra == {AW{1'b0}})) begin
                w_rd = '0;
            end else if ((BYPASS == 1) && i_we3 && !i_clr && (i_a3 == w_ra)) begin
                w_rd = i_wd3;
            end else begin
                w_rd = r_mem[w_ra];
            end
        end

        assign o_rd[k*DW +: DW] = w_rd;
    end

    assign o_busy = w_busy;

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench: dut0 uses defaults (ZERO_REG=1, BYPASS=0, NR=2), dut1 uses
// ZERO_REG=0, BYPASS=1, NR=3; both share clock, reset and write port.
module tb_regfile_multiport;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [9:0]  ra0;
    logic [14:0] ra1;
    logic [63:0] rd0;
    logic [95:0] rd1;
    logic        busy0;
    logic        busy1;

    int checks = 0;
    int errors = 0;
    int n;
    logic [31:0] acc0;
    logic [31:0] acc1;

    always #5 clk = ~clk;

    regfile_multiport dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (clr),
        .i_we3   (we3),
        .i_a3    (a3),
        .i_wd3   (wd3),
        .i_ra    (ra0),
        .o_rd    (rd0),
        .o_busy  (busy0)
    );

    regfile_multiport #(
        .DW (32), .AW (5), .NR (3), .ZERO_REG (0), .BYPASS (1)
    ) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (clr),
        .i_we3   (we3),
        .i_a3    (a3),
        .i_wd3   (wd3),
        .i_ra    (ra1),
        .o_rd    (rd1),
        .o_busy  (busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts edges until both DUTs leave BUSY, bounded at 100
    task automatic count_busy(output int cnt);
        cnt = 101;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (!busy0 && !busy1) begin
                cnt = i;
                break;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; we3 = 1'b0; a3 = 5'd0; wd3 = 32'd0;
        ra0 = {5'd2, 5'd1};
        ra1 = {5'd3, 5'd2, 5'd1};

        // 1. reset and clear timing
        tick(); tick();
        chk("reset_busy0", {31'd0, busy0}, 32'd1);
        chk("reset_busy1", {31'd0, busy1}, 32'd1);
        rst_n = 1'b1;
        n = 101;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (i == 16) begin
                chk("clear_rd0_p0", rd0[31:0], 32'd0);
                chk("clear_rd0_p1", rd0[63:32], 32'd0);
            end
            if (!busy0) begin
                n = i;
                break;
            end
        end
        chk("reset_clear_edges", n, 32'd32);
        chk("busy1_follows", {31'd0, busy1}, 32'd0);
        chk("post_clear_rd0_p0", rd0[31:0], 32'd0);
        chk("post_clear_rd0_p1", rd0[63:32], 32'd0);

        // 2. write then read; no bypass on dut0, bypass on dut1
        we3 = 1'b1; a3 = 5'd7; wd3 = 32'hDEADBEEF;
        ra0 = {5'd1, 5'd7};
        ra1 = {5'd1, 5'd1, 5'd7};
        #1;
        chk("nobypass_old_value", rd0[31:0], 32'd0);
        chk("bypass_p0_same_cycle", rd1[31:0], 32'hDEADBEEF);
        tick();
        we3 = 1'b0;
        #1;
        chk("write_read_p0", rd0[31:0], 32'hDEADBEEF);

        // 3. zero register on dut0, ordinary register on dut1
        we3 = 1'b1; a3 = 5'd0; wd3 = 32'hFFFFFFFF;
        tick();
        we3 = 1'b0;
        ra0 = {5'd7, 5'd0};
        ra1 = {5'd7, 5'd7, 5'd0};
        #1;
        chk("zero_reg_on", rd0[31:0], 32'd0);
        chk("zero_reg_off", rd1[31:0], 32'hFFFFFFFF);

        // 4. bypass
        we3 = 1'b1; a3 = 5'd5; wd3 = 32'h0000AAAA;
        tick();
        a3 = 5'd6; wd3 = 32'h00006666;
        tick();
        a3 = 5'd5; wd3 = 32'h00001234;
        ra0 = {5'd5, 5'd6};
        ra1 = {5'd0, 5'd5, 5'd6};
        #1;
        chk("bypass_p1", rd1[63:32], 32'h00001234);
        chk("bypass_p0_unaffected", rd1[31:0], 32'h00006666);
        chk("nobypass_p1", rd0[63:32], 32'h0000AAAA);
        tick();
        we3 = 1'b0;
        #1;
        chk("after_bypass_write", rd0[63:32], 32'h00001234);

        // 5. fill, then CLR with a colliding write, WE3 pulses during BUSY
        for (int i = 1; i < 32; i++) begin
            we3 = 1'b1; a3 = 5'(i); wd3 = 32'h10000000 | 32'(i);
            tick();
        end
        we3 = 1'b0;
        ra0 = {5'd31, 5'd3};
        #1;
        chk("fill_r3", rd0[31:0], 32'h10000003);
        chk("fill_r31", rd0[63:32], 32'h1000001F);
        clr = 1'b1; we3 = 1'b1; a3 = 5'd3; wd3 = 32'h00000BAD;
        tick();
        chk("clr_busy", {31'd0, busy0}, 32'd1);
        n = 101;
        for (int i = 1; i <= 100; i++) begin
            we3 = i[0];
            a3 = 5'(i - 2);
            wd3 = 32'hCAFE0000 | 32'(i);
            tick();
            if (!busy0) begin
                n = i;
                break;
            end
        end
        clr = 1'b0; we3 = 1'b0;
        chk("clr_busy_edges", n, 32'd32);
        acc0 = 32'd0; acc1 = 32'd0;
        for (int i = 0; i < 32; i++) begin
            ra0 = {5'(i), 5'(i)};
            ra1 = {5'(i), 5'(i), 5'(i)};
            #1;
            acc0 = acc0 | rd0[31:0] | rd0[63:32];
            acc1 = acc1 | rd1[31:0] | rd1[63:32] | rd1[95:64];
        end
        chk("all_zero_dut0", acc0, 32'd0);
        chk("all_zero_dut1", acc1, 32'd0);

        // 6. reset mid-clear, then third read port
        we3 = 1'b1; a3 = 5'd20; wd3 = 32'h00002020;
        tick();
        we3 = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        tick();
        chk("midclear_reset_busy", {31'd0, busy0}, 32'd1);
        rst_n = 1'b1;
        count_busy(n);
        chk("midclear_restart_edges", n, 32'd32);
        ra1 = {5'd20, 5'd20, 5'd20};
        #1;
        chk("midclear_r20_cleared", rd1[95:64], 32'd0);
        we3 = 1'b1; a3 = 5'd9; wd3 = 32'h00000099;
        tick();
        we3 = 1'b0;
        ra1 = {5'd9, 5'd9, 5'd9};
        #1;
        chk("p2_value", rd1[95:64], 32'h00000099);
        chk("p2_eq_p0", rd1[95:64], rd1[31:0]);
        chk("p2_eq_p1", rd1[95:64], rd1[63:32]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
